// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave fronting a word-addressed synchronous RAM with independent write and read engines
module axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2     = 10
) (
  input  logic                          CCLK,
  input  logic                          CRST,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int DEPTH = 2 ** MEM_DEPTH_LOG2;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [C_S_AXI_DATA_WIDTH-1:0] r_word;
  logic up;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [MEM_DEPTH_LOG2-1:0] w_idx, r_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_fixed, w_err, r_fixed, r_err;
  logic aw_hs, w_hs, w_end, ar_hs, r_hs, r_last, we;
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign w_end = w_hs & (w_cnt == w_len);
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs = S_AXI_RVALID & S_AXI_RREADY;
  assign r_last = r_cnt == r_len;
  assign we = w_hs & ~w_err;
  // Holds both address channels not-ready until the first edge after reset release
  always_ff @(posedge CCLK or posedge CRST)
    if (CRST) up <= 1'b0;
    else up <= 1'b1;
  // Write engine state register
  always_ff @(posedge CCLK or posedge CRST)
    if (CRST) w_state <= W_IDLE;
    else w_state <= w_next;
  // Write engine next state: address, then data beats until LEN reached, then response
  always_comb begin
    w_next = w_state;
    w_next = (w_state == W_IDLE && aw_hs) ? W_DATA :
             (w_state == W_DATA && w_end) ? W_RESP :
             (w_state == W_RESP && S_AXI_BREADY) ? W_IDLE : w_state;
  end
  // Write engine outputs
  always_comb begin
    S_AXI_AWREADY = up && w_state == W_IDLE;
    S_AXI_WREADY = w_state == W_DATA;
    S_AXI_BVALID = w_state == W_RESP;
    S_AXI_BRESP = {S_AXI_BVALID & w_err, 1'b0};
    S_AXI_BID = w_id;
  end
  // Write burst bookkeeping; a WLAST that disagrees with the beat count poisons the response
  always_ff @(posedge CCLK or posedge CRST)
    if (CRST) begin
      w_id <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_fixed <= 1'b0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id <= S_AXI_AWID;
      w_idx <= S_AXI_AWADDR[MEM_DEPTH_LOG2+1:2];
      w_len <= S_AXI_AWLEN;
      w_cnt <= '0;
      w_fixed <= S_AXI_AWBURST == 2'b00;
      w_err <= (S_AXI_AWSIZE != 3'b010) | S_AXI_AWBURST[1];
    end else if (w_hs) begin
      w_idx <= w_fixed ? w_idx : w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
      w_err <= w_err | (S_AXI_WLAST != (w_cnt == w_len));
    end
  // RAM: byte-masked write, registered read-first fetch; contents survive reset
  always_ff @(posedge CCLK) begin
    if (we && S_AXI_WSTRB[0]) mem[w_idx][7:0] <= S_AXI_WDATA[7:0];
    if (we && S_AXI_WSTRB[1]) mem[w_idx][15:8] <= S_AXI_WDATA[15:8];
    if (we && S_AXI_WSTRB[2]) mem[w_idx][23:16] <= S_AXI_WDATA[23:16];
    if (we && S_AXI_WSTRB[3]) mem[w_idx][31:24] <= S_AXI_WDATA[31:24];
    if (r_state == R_FETCH) r_word <= mem[r_idx];
  end
  // Read engine state register
  always_ff @(posedge CCLK or posedge CRST)
    if (CRST) r_state <= R_IDLE;
    else r_state <= r_next;
  // Read engine next state: each beat costs a fetch cycle and a data cycle
  always_comb begin
    r_next = r_state;
    r_next = (r_state == R_IDLE && ar_hs) ? R_FETCH :
             (r_state == R_FETCH) ? R_DATA :
             (r_state == R_DATA && r_hs) ? (r_last ? R_IDLE : R_FETCH) : r_state;
  end
  // Read engine outputs; errored bursts return zero data
  always_comb begin
    S_AXI_ARREADY = up && r_state == R_IDLE;
    S_AXI_RVALID = r_state == R_DATA;
    S_AXI_RDATA = (S_AXI_RVALID && !r_err) ? r_word : '0;
    S_AXI_RRESP = {S_AXI_RVALID & r_err, 1'b0};
    S_AXI_RLAST = S_AXI_RVALID & r_last;
    S_AXI_RID = r_id;
  end
  // Read burst bookkeeping
  always_ff @(posedge CCLK or posedge CRST)
    if (CRST) begin
      r_id <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_fixed <= 1'b0;
      r_err <= 1'b0;
    end else if (ar_hs) begin
      r_id <= S_AXI_ARID;
      r_idx <= S_AXI_ARADDR[MEM_DEPTH_LOG2+1:2];
      r_len <= S_AXI_ARLEN;
      r_cnt <= '0;
      r_fixed <= S_AXI_ARBURST == 2'b00;
      r_err <= (S_AXI_ARSIZE != 3'b010) | S_AXI_ARBURST[1];
    end else if (r_hs && !r_last) begin
      r_idx <= r_fixed ? r_idx : r_idx + 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
endmodule
